// File: rtl/vga_pkg.sv
// Shared timing constants, widths and pixel payload types for the VGA scan path.
// Default timing is 640x480@60 (800 x 525 totals).
package vga_pkg;

    localparam int unsigned H_ACTIVE     = 640;
    localparam int unsigned H_FP         = 16;
    localparam int unsigned H_SYNC       = 96;
    localparam int unsigned H_BP         = 48;
    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam int unsigned V_ACTIVE     = 480;
    localparam int unsigned V_FP         = 10;
    localparam int unsigned V_SYNC       = 2;
    localparam int unsigned V_BP         = 33;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned ROW_W = 9;
    localparam int unsigned COL_W = 10;
    localparam int unsigned PIX_W = 12;
    localparam int unsigned CH_W  = 4;
    localparam int unsigned DIV_W = 4;

    // RGB444 fields: R[11:8], G[7:4], B[3:0]
    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb444_t;

    // Per-pixel timing flags carried alongside the colour lookup latency
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } scan_tap_t;

    function automatic rgb444_t rgb_gate(input logic en, input logic [PIX_W-1:0] pix);
        return en ? rgb444_t'(pix) : rgb444_t'('0);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active-region and raw sync-window decode.
// Used once for the horizontal axis and once for the vertical axis.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL      = H_TOTAL,
    parameter int unsigned SYNC_START = H_SYNC_START,
    parameter int unsigned SYNC_END   = H_SYNC_END,
    parameter int unsigned ACTIVE     = H_ACTIVE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             wrap,
    output logic             active,
    output logic             sync_raw
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // wrap flags the terminal count; the caller qualifies it with its own enable
    assign wrap = (cnt_q == CNT_W'(TOTAL - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign cnt_nxt  = cnt_d;
    assign active   = (cnt_q < CNT_W'(ACTIVE));
    assign sync_raw = (cnt_q >= CNT_W'(SYNC_START)) && (cnt_q < CNT_W'(SYNC_END));

endmodule

// File: rtl/vga_scan_ctrl.sv
// Raster scan controller: pixel-strobe divider, h/v counters, framebuffer address,
// latency-matched sync/blanking pipeline, registered RGB and frame event pulses.
module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned PIPE_LAT = 1,
    parameter logic        SYNC_ACT = 1'b0,
    parameter int unsigned H_VIS    = H_ACTIVE,
    parameter int unsigned H_FRONT  = H_FP,
    parameter int unsigned H_PULSE  = H_SYNC,
    parameter int unsigned H_BACK   = H_BP,
    parameter int unsigned V_VIS    = V_ACTIVE,
    parameter int unsigned V_FRONT  = V_FP,
    parameter int unsigned V_PULSE  = V_SYNC,
    parameter int unsigned V_BACK   = V_BP
) (
    input  logic             clka,
    input  logic             rst,
    output logic [ROW_W-1:0] row_addr,
    output logic [COL_W-1:0] col_addr,
    input  logic [PIX_W-1:0] vga_data,
    output logic [CH_W-1:0]  r,
    output logic [CH_W-1:0]  g,
    output logic [CH_W-1:0]  b,
    output logic             hs,
    output logic             vs,
    output logic             pix_en,
    output logic             frame_start,
    output logic             vblank_start
);

    localparam int unsigned LINE_LEN    = H_VIS + H_FRONT + H_PULSE + H_BACK;
    localparam int unsigned HS_START    = H_VIS + H_FRONT;
    localparam int unsigned HS_END      = HS_START + H_PULSE;
    localparam int unsigned FRAME_LINES = V_VIS + V_FRONT + V_PULSE + V_BACK;
    localparam int unsigned VS_START    = V_VIS + V_FRONT;
    localparam int unsigned VS_END      = VS_START + V_PULSE;

    // ---------------- pixel strobe divider ----------------
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             div_last;

    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_d = div_last ? '0 : div_q + DIV_W'(1);
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Gated by rst so a divide-by-1 build does not strobe while held in reset
    assign pix_en = div_last & ~rst;

    // ---------------- axis counters ----------------
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] h_nxt;
    logic             h_wrap;
    logic             h_act;
    logic             h_sync;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] v_nxt;
    logic             v_wrap;
    logic             v_act;
    logic             v_sync;
    logic             v_en;

    assign v_en = h_wrap & pix_en;

    vga_axis_counter #(
        .TOTAL      (LINE_LEN),
        .SYNC_START (HS_START),
        .SYNC_END   (HS_END),
        .ACTIVE     (H_VIS)
    ) u_h_axis (
        .clk      (clka),
        .rst      (rst),
        .en       (pix_en),
        .cnt      (h_cnt),
        .cnt_nxt  (h_nxt),
        .wrap     (h_wrap),
        .active   (h_act),
        .sync_raw (h_sync)
    );

    vga_axis_counter #(
        .TOTAL      (FRAME_LINES),
        .SYNC_START (VS_START),
        .SYNC_END   (VS_END),
        .ACTIVE     (V_VIS)
    ) u_v_axis (
        .clk      (clka),
        .rst      (rst),
        .en       (v_en),
        .cnt      (v_cnt),
        .cnt_nxt  (v_nxt),
        .wrap     (v_wrap),
        .active   (v_act),
        .sync_raw (v_sync)
    );

    assert property (@(posedge clka) disable iff (rst)
        (h_cnt < CNT_W'(LINE_LEN)) && (v_cnt < CNT_W'(FRAME_LINES)));

    // ---------------- framebuffer address ----------------
    // Loaded from the post-strobe counter values so the address always names the current pixel
    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] row_d;
    logic [COL_W-1:0] col_q;
    logic [COL_W-1:0] col_d;
    logic             act_nxt;

    assign act_nxt = (h_nxt < CNT_W'(H_VIS)) && (v_nxt < CNT_W'(V_VIS));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (pix_en) begin
            if (act_nxt) begin
                row_d = ROW_W'(v_nxt);
                col_d = COL_W'(h_nxt);
            end else begin
                row_d = '0;
                col_d = '0;
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_addr = row_q;
    assign col_addr = col_q;

    // ---------------- timing-flag delay line ----------------
    scan_tap_t tap_cur;
    scan_tap_t tap_del;

    always_comb begin
        tap_cur        = '0;
        tap_cur.active = h_act & v_act;
        tap_cur.hs     = h_sync;
        tap_cur.vs     = v_sync;
    end

    generate
        if (PIPE_LAT == 0) begin : g_nopipe
            assign tap_del = tap_cur;
        end else if (PIPE_LAT == 1) begin : g_pipe1
            scan_tap_t pipe_q;

            always_ff @(posedge clka) begin
                if (rst) begin
                    pipe_q <= '0;
                end else if (pix_en) begin
                    pipe_q <= tap_cur;
                end
            end

            assign tap_del = pipe_q;
        end else begin : g_pipen
            scan_tap_t [PIPE_LAT-1:0] pipe_q;

            always_ff @(posedge clka) begin
                if (rst) begin
                    pipe_q <= '0;
                end else if (pix_en) begin
                    pipe_q <= {pipe_q[PIPE_LAT-2:0], tap_cur};
                end
            end

            assign tap_del = pipe_q[PIPE_LAT-1];
        end
    endgenerate

    // ---------------- connector output register ----------------
    rgb444_t rgb_q;
    rgb444_t rgb_d;
    logic    hs_q;
    logic    hs_d;
    logic    vs_q;
    logic    vs_d;

    always_comb begin
        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (pix_en) begin
            rgb_d = rgb_gate(tap_del.active, vga_data);
            hs_d  = tap_del.hs ? SYNC_ACT : ~SYNC_ACT;
            vs_d  = tap_del.vs ? SYNC_ACT : ~SYNC_ACT;
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            rgb_q <= '0;
            hs_q  <= ~SYNC_ACT;
            vs_q  <= ~SYNC_ACT;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign r  = rgb_q.r;
    assign g  = rgb_q.g;
    assign b  = rgb_q.b;
    assign hs = hs_q;
    assign vs = vs_q;

    // ---------------- frame events ----------------
    // Decoded on the strobe that moves the scan onto the target position, so each lasts one clka
    assign frame_start  = pix_en & h_wrap & v_wrap;
    assign vblank_start = pix_en & h_wrap & (v_cnt == CNT_W'(V_VIS - 1));

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: three builds (full timing /4 lat1, reduced timing /1 lat0,
// reduced timing /3 lat2 active-high sync) checked every cycle against a closed-form scan model.
module tb_vga_scan_ctrl;

    logic clka = 1'b0;
    logic rst  = 1'b1;

    always #5 clka = ~clka;

    int checks   = 0;
    int failures = 0;

    // ---------------- DUT signals ----------------
    logic [8:0]  row0, row1, row2;
    logic [9:0]  col0, col1, col2;
    logic [11:0] vd0 = '0;
    logic [11:0] vd1;
    logic [11:0] vd2 = '0;
    logic [11:0] vd2a = '0;
    logic [3:0]  r0, g0, b0, r1, g1, b1, r2, g2, b2;
    logic        hs0, vs0, pe0, fs0, vb0;
    logic        hs1, vs1, pe1, fs1, vb1;
    logic        hs2, vs2, pe2, fs2, vb2;

    vga_scan_ctrl #(.CLK_DIV(4), .PIPE_LAT(1), .SYNC_ACT(1'b0)) dut0 (
        .clka(clka), .rst(rst), .row_addr(row0), .col_addr(col0), .vga_data(vd0),
        .r(r0), .g(g0), .b(b0), .hs(hs0), .vs(vs0), .pix_en(pe0),
        .frame_start(fs0), .vblank_start(vb0)
    );

    vga_scan_ctrl #(.CLK_DIV(1), .PIPE_LAT(0), .SYNC_ACT(1'b0),
                    .H_VIS(16), .H_FRONT(2), .H_PULSE(3), .H_BACK(3),
                    .V_VIS(10), .V_FRONT(2), .V_PULSE(2), .V_BACK(1)) dut1 (
        .clka(clka), .rst(rst), .row_addr(row1), .col_addr(col1), .vga_data(vd1),
        .r(r1), .g(g1), .b(b1), .hs(hs1), .vs(vs1), .pix_en(pe1),
        .frame_start(fs1), .vblank_start(vb1)
    );

    vga_scan_ctrl #(.CLK_DIV(3), .PIPE_LAT(2), .SYNC_ACT(1'b1),
                    .H_VIS(16), .H_FRONT(2), .H_PULSE(3), .H_BACK(3),
                    .V_VIS(10), .V_FRONT(2), .V_PULSE(2), .V_BACK(1)) dut2 (
        .clka(clka), .rst(rst), .row_addr(row2), .col_addr(col2), .vga_data(vd2),
        .r(r2), .g(g2), .b(b2), .hs(hs2), .vs(vs2), .pix_en(pe2),
        .frame_start(fs2), .vblank_start(vb2)
    );

    // ---------------- colour lookups with the configured latency ----------------
    function automatic logic [11:0] lut(input logic [8:0] row, input logic [9:0] col);
        return {row[3:0], col[7:4], col[3:0]};
    endfunction

    always @(posedge clka) if (pe0) vd0 <= lut(row0, col0);
    assign vd1 = lut(row1, col1);
    always @(posedge clka) begin
        if (pe2) begin
            vd2a <= lut(row2, col2);
            vd2  <= vd2a;
        end
    end

    // ---------------- scan model ----------------
    typedef struct {
        int col; int row; int r; int g; int b;
        int hs; int vs; int pe; int fs; int vb;
    } exp_t;

    // cyc = clka cycles since reset release (cycle 0 = first cycle with rst low)
    function automatic exp_t model(input int cyc, input bit in_rst, input int d, input int lat,
                                   input int sa, input int ha, input int hf, input int hsy,
                                   input int hb, input int va, input int vf, input int vsy,
                                   input int vbp);
        exp_t e;
        int ht, vt, ft, s, k, h, v, hk, vk;
        ht = ha + hf + hsy + hb;
        vt = va + vf + vsy + vbp;
        ft = ht * vt;
        s  = cyc / d;
        k  = s - lat - 1;
        h  = s % ht;
        v  = (s / ht) % vt;
        e.pe  = (!in_rst && (cyc % d == d - 1)) ? 1 : 0;
        e.col = (h < ha && v < va) ? h : 0;
        e.row = (h < ha && v < va) ? v : 0;
        e.fs  = (e.pe == 1 && ((s + 1) % ft == 0)) ? 1 : 0;
        e.vb  = (e.pe == 1 && ((s + 1) % ft == va * ht)) ? 1 : 0;
        e.hs  = 1 - sa;
        e.vs  = 1 - sa;
        e.r   = 0;
        e.g   = 0;
        e.b   = 0;
        if (k >= 0) begin
            hk = k % ht;
            vk = (k / ht) % vt;
            if (hk >= ha + hf && hk < ha + hf + hsy) e.hs = sa;
            if (vk >= va + vf && vk < va + vf + vsy) e.vs = sa;
            if (hk < ha && vk < va) begin
                e.r = vk % 16;
                e.g = (hk / 16) % 16;
                e.b = hk % 16;
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_inst(input string tag, input exp_t e, input int col, input int row,
                              input int rr, input int gg, input int bb, input int h,
                              input int v, input int pe, input int fs, input int vb);
        chk({tag, ".col_addr"}, col, e.col);
        chk({tag, ".row_addr"}, row, e.row);
        chk({tag, ".r"}, rr, e.r);
        chk({tag, ".g"}, gg, e.g);
        chk({tag, ".b"}, bb, e.b);
        chk({tag, ".hs"}, h, e.hs);
        chk({tag, ".vs"}, v, e.vs);
        chk({tag, ".pix_en"}, pe, e.pe);
        chk({tag, ".frame_start"}, fs, e.fs);
        chk({tag, ".vblank_start"}, vb, e.vb);
    endtask

    // Cycle tracker: reset edges zero it, every other edge advances it
    int mcyc     = 0;
    bit mvalid   = 1'b0;
    bit last_rst = 1'b0;

    always @(posedge clka) begin
        last_rst <= rst;
        if (rst) begin
            mcyc   <= 0;
            mvalid <= 1'b1;
        end else begin
            mcyc <= mcyc + 1;
        end
    end

    // Per-cycle compare; skips only the cycle where rst is raised but not yet clocked in
    initial begin
        exp_t e0, e1, e2;
        forever begin
            @(negedge clka);
            if (mvalid && !(rst && !last_rst)) begin
                e0 = model(mcyc, rst, 4, 1, 0, 640, 16, 96, 48, 480, 10, 2, 33);
                e1 = model(mcyc, rst, 1, 0, 0, 16, 2, 3, 3, 10, 2, 2, 1);
                e2 = model(mcyc, rst, 3, 2, 1, 16, 2, 3, 3, 10, 2, 2, 1);
                check_inst("d0", e0, int'(col0), int'(row0), int'(r0), int'(g0), int'(b0),
                           int'(hs0), int'(vs0), int'(pe0), int'(fs0), int'(vb0));
                check_inst("d1", e1, int'(col1), int'(row1), int'(r1), int'(g1), int'(b1),
                           int'(hs1), int'(vs1), int'(pe1), int'(fs1), int'(vb1));
                check_inst("d2", e2, int'(col2), int'(row2), int'(r2), int'(g2), int'(b2),
                           int'(hs2), int'(vs2), int'(pe2), int'(fs2), int'(vb2));
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        int hs_low0, colmax0, rowmax0, fs1_cnt, vb1_cnt, fs2_cnt, vs1_low;
        int fs0_c, fs1_c, fs2_c;
        hs_low0 = 0; colmax0 = 0; rowmax0 = 0; fs1_cnt = 0; vb1_cnt = 0;
        fs2_cnt = 0; vs1_low = 0; fs0_c = 0; fs1_c = 0; fs2_c = 0;

        rst = 1'b1;
        repeat (2) @(posedge clka);
        @(negedge clka);
        chk("lit_rst_hs0", int'(hs0), 1);
        chk("lit_rst_vs0", int'(vs0), 1);
        chk("lit_rst_rgb0", int'({r0, g0, b0}), 0);
        chk("lit_rst_pe1", int'(pe1), 0);
        chk("lit_rst_hs2", int'(hs2), 0);
        @(posedge clka);
        #1 rst = 1'b0;

        // First scan from reset: one full line of dut0, many small frames of dut1/dut2
        for (int c = 0; c < 4400; c++) begin
            @(negedge clka);
            if (!hs0) hs_low0++;
            if (int'(col0) > colmax0) colmax0 = int'(col0);
            if (int'(row0) > rowmax0) rowmax0 = int'(row0);
            if (fs1) fs1_cnt++;
            if (vb1) vb1_cnt++;
            if (fs2) fs2_cnt++;
            if (!vs1) vs1_low++;
            if (c == 2) chk("lit_pe0_cyc2", int'(pe0), 0);
            if (c == 3) chk("lit_pe0_cyc3", int'(pe0), 1);
            if (c == 7) chk("lit_pe0_cyc7", int'(pe0), 1);
            if (c == 0) chk("lit_pe1_cyc0", int'(pe1), 1);
            if (c == 4399) begin
                chk("lit_col0_at_h299", int'(col0), 299);
                chk("lit_row0_at_v1", int'(row0), 1);
            end
        end
        chk("lit_hs0_low_cycles", hs_low0, 384);
        chk("lit_col0_max", colmax0, 639);
        chk("lit_row0_max", rowmax0, 1);
        chk("lit_fs1_count", fs1_cnt, 12);
        chk("lit_vb1_count", vb1_cnt, 12);
        chk("lit_fs2_count", fs2_cnt, 4);
        chk("lit_vs1_low_cycles", vs1_low, 576);

        // Mid-frame reset for two cycles (dut0 sits at h=300, v=1)
        @(posedge clka);
        #1 rst = 1'b1;
        @(posedge clka);
        @(negedge clka);
        chk("lit_midrst_col0", int'(col0), 0);
        chk("lit_midrst_rgb0", int'({r0, g0, b0}), 0);
        chk("lit_midrst_hs0", int'(hs0), 1);
        chk("lit_midrst_fs1", int'(fs1), 0);
        @(posedge clka);
        #1 rst = 1'b0;

        for (int c = 0; c < 2000; c++) begin
            @(negedge clka);
            if (fs0) fs0_c++;
            if (fs1) fs1_c++;
            if (fs2) fs2_c++;
            if (c == 0) chk("lit_restart_col0", int'(col0), 0);
            if (c == 3) chk("lit_restart_pe0", int'(pe0), 1);
            if (c == 4) chk("lit_restart_col0_c4", int'(col0), 1);
        end
        chk("lit_restart_fs0_count", fs0_c, 0);
        chk("lit_restart_fs1_count", fs1_c, 5);
        chk("lit_restart_fs2_count", fs2_c, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
